// File: rtl/wb_guard_pkg.sv
// Shared definitions for the wishbone timeout guard.
//   state_t          : FSM encoding (IDLE / WAIT / TOACK)
//   ERR_DATA_DEFAULT : read data returned on a timed-out transfer
package wb_guard_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    TOACK = 2'd2
  } state_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/wishbone_timeout_guard.sv
// Wishbone timeout guard, placed between the Caravel wishbone master and the
// 1-to-8 address decoder. Transfers pass through with zero added latency. If
// the decoder does not ack within TIMEOUT_CYCLES wait cycles, the guard drops
// cyc/stb towards the decoder and returns a one-cycle error ack carrying
// ERR_DATA. Timeouts are counted (saturating) and the offending address kept.
//
// Optional feature (macro WB_TIMEOUT_IRQ_EN): sticky irq_o set on every
// timeout, cleared by an irq_clr_i pulse; a set in the same cycle wins.
// Without the macro irq_o is tied low and irq_clr_i is ignored.
//
// Ports:
//   wb_clk_i, wb_rst_i          clock, asynchronous active-high reset
//   wbs_m_*_i / wbs_m_*_o       upstream (master side) wishbone port
//   wbs_s_*_o / wbs_s_*_i       downstream (decoder side) wishbone port
//   err_cnt_o                   saturating timeout count
//   err_adr_o                   address of the most recent timed-out transfer
//   irq_o, irq_clr_i            sticky timeout interrupt and its clear
module wishbone_timeout_guard
  import wb_guard_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT,
  parameter int          ERRCNT_W       = 8
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wbs_m_cyc_i,
  input  logic                wbs_m_stb_i,
  input  logic [31:0]         wbs_m_adr_i,
  input  logic                wbs_m_we_i,
  input  logic [31:0]         wbs_m_dat_i,
  input  logic [3:0]          wbs_m_sel_i,
  output logic [31:0]         wbs_m_dat_o,
  output logic                wbs_m_ack_o,
  output logic                wbs_s_cyc_o,
  output logic                wbs_s_stb_o,
  output logic [31:0]         wbs_s_adr_o,
  output logic                wbs_s_we_o,
  output logic [31:0]         wbs_s_dat_o,
  output logic [3:0]          wbs_s_sel_o,
  input  logic [31:0]         wbs_s_dat_i,
  input  logic                wbs_s_ack_i,
  output logic [ERRCNT_W-1:0] err_cnt_o,
  output logic [31:0]         err_adr_o,
  output logic                irq_o,
  input  logic                irq_clr_i
);

  localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  state_t                state;
  state_t                state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic                  req;
  logic                  to_enter;

  assign req = wbs_m_cyc_i & wbs_m_stb_i;

  // Next-state logic. A genuine ack or a master abort always beats the
  // timeout, including in the cycle where cnt reaches CNT_MAX.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    to_enter  = 1'b0;
    case (state)
      IDLE: begin
        if (req && !wbs_s_ack_i) begin
          state_nxt = WAIT;
          cnt_nxt   = CNT_W'(1);
        end
      end
      WAIT: begin
        if (!req || wbs_s_ack_i) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = TOACK;
          to_enter  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      TOACK: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Bus muxing: address/data/control pass straight through; only cyc/stb
  // and the upstream ack/data are overridden while the error ack is issued.
  always_comb begin
    wbs_s_adr_o = wbs_m_adr_i;
    wbs_s_we_o  = wbs_m_we_i;
    wbs_s_dat_o = wbs_m_dat_i;
    wbs_s_sel_o = wbs_m_sel_i;
    wbs_s_cyc_o = wbs_m_cyc_i;
    wbs_s_stb_o = wbs_m_stb_i;
    wbs_m_ack_o = wbs_s_ack_i & req;
    wbs_m_dat_o = wbs_s_dat_i;
    if (state == TOACK) begin
      wbs_s_cyc_o = 1'b0;
      wbs_s_stb_o = 1'b0;
      wbs_m_ack_o = 1'b1;
      wbs_m_dat_o = ERR_DATA;
    end
  end

  // Error log: counter holds at all-ones instead of wrapping.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      err_cnt_o <= '0;
      err_adr_o <= '0;
    end else if (to_enter) begin
      if (err_cnt_o != {ERRCNT_W{1'b1}}) begin
        err_cnt_o <= err_cnt_o + ERRCNT_W'(1);
      end
      err_adr_o <= wbs_m_adr_i;
    end
  end

`ifdef WB_TIMEOUT_IRQ_EN
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      irq_o <= 1'b0;
    end else if (to_enter) begin
      irq_o <= 1'b1;
    end else if (irq_clr_i) begin
      irq_o <= 1'b0;
    end
  end
`else
  logic unused_irq_clr;
  assign unused_irq_clr = irq_clr_i;
  assign irq_o          = 1'b0;
`endif

endmodule
